dbg_slave_chan_ctrl: RTL and testbench
======================================

Name:
dbg_slave_chan_ctrl

Overview:
- Parametrised debug-slave command controller for the Nios II debug path.
- Owns the DR shift register, per-IR capture mux, update latch (jdo) and per-channel action strobes. Unlike the previous generation, it has N channels, a valid/ready action handshake to the CPU side, and sticky overrun reporting.
- Runs entirely in the system clock domain. Virtual-JTAG state strobes arrive pre-synchronised as single-cycle pulses, qualified by shift_en.

Parameters:
- IR_W, 2, instruction register width; selects the channel.
- NUM_CH, 4, number of channels; must be at most 2**IR_W.
- DATA_W, 32, readback word width per channel.
- DR_W, 38, data register width; must be at least DATA_W+2.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- shift_en  in  1  one-cycle strobe per TCK edge; qualifies sdr
- cdr  in  1  capture-DR pulse
- sdr  in  1  shift-DR level
- udr  in  1  update-DR pulse
- uir  in  1  update-IR pulse
- ir_in  in  IR_W  current instruction (channel select)
- tdi  in  1  serial data in
- tdo  out  1  serial data out
- ir_out  out  IR_W  status returned on IR capture
- ch_rdata  in  NUM_CH*DATA_W  readback words; channel k occupies bits [k*DATA_W +: DATA_W]
- jdo  out  DR_W  last accepted update word
- take_action  out  NUM_CH  one-hot action request; held until act_ready
- take_no_action  out  NUM_CH  one-hot no-action request; held until act_ready
- act_ready  in  1  CPU side accepts the pending request
- busy  out  1  a request is pending
- overrun  out  1  sticky; an update was dropped

Behaviour:
- Decided: one clock, clk; reset is asynchronous and active-high.
- On reset: sr, jdo, take_action, take_no_action, busy and overrun are all 0; tdo=0; ir_out=0; FSM goes to IDLE.
- Reset mid-shift or mid-request drops all state, with no residual pulses.
- tdo = sr[0], combinational from the register.
- ir_out[0]=busy; ir_out[1]=overrun (when IR_W>=2); higher bits are 0.
- FSM states: IDLE, SHIFT, PEND.
  - IDLE to SHIFT on cdr.
  - SHIFT to PEND on udr, when the word is accepted.
  - SHIFT to IDLE on uir.
  - PEND to IDLE when act_ready is high in the same cycle as a strobe.
- Capture on cdr, effective next cycle:
  - sr[DATA_W-1:0] = ch_rdata word of channel ir_in, or 0 if ir_in >= NUM_CH.
  - sr[DATA_W] = busy; sr[DATA_W+1] = overrun; bits above are 0.
- Shift: when sdr && shift_en && !cdr, sr <= {tdi, sr[DR_W-1:1]} (LSB-first out, MSB-first in). Exactly one bit per shift_en pulse.
- Priority in one cycle: cdr > shift > udr.
- Update on udr when not busy:
  - jdo <= sr; busy <= 1.
  - If sr[DR_W-1]=1, take_action[ir_in] <= 1; otherwise take_no_action[ir_in] <= 1.
  - Latency: 1 cycle from udr to the strobe.
- Update with ir_in >= NUM_CH: jdo is updated, no strobe fires, busy stays 0.
- Handshake:
  - The strobe and busy hold until a cycle with act_ready=1; both clear on the next edge.
  - act_ready while idle is ignored.
  - At most one strobe bit is set at any time.
- udr while busy: jdo and the strobe are unchanged; overrun <= 1. This holds even if act_ready=1 in the same cycle, because the accept is processed and the new update is still dropped.
- overrun clears only on uir, or on reset.
- sdr without shift_en leaves sr unchanged.
- Shifting more than DR_W bits wraps naturally: old bits fall out of tdo.

Decomposition:
- Shared package dbg_slave_pkg holds:
  - FSM state enum.
  - Capture bit-index constants: CAP_BUSY_BIT=DATA_W, CAP_OVR_BIT=DATA_W+1.
  - Action-bit index ACT_BIT=DR_W-1.
  - ir_out bit constants.
- One sub-module, dbg_slave_shift_reg: parametrised DR_W shift register with capture/shift/tdo.
- The FSM, handshake and channel demux stay in the top level.

Test Plan:
- Reset mid-shift: assert reset after 10 shift_en pulses -> sr=0, tdo=0, jdo=0, no strobes, busy=0, overrun=0.
- Capture and shift: ch_rdata ch2=0xDEADBEEF, ir_in=2, cdr, then 38 shift_en with tdi=0 -> tdo sequence LSB-first is 0xDEADBEEF, followed by busy=0, overrun=0, then zeros.
- Action: shift in 38'h20_0000_1234 (bit37=1) with ir_in=1, pulse udr -> next cycle jdo=38'h20_0000_1234, take_action=4'b0010, busy=1; held for 5 cycles; act_ready on cycle 6 -> cleared the following cycle.
- No-action: bit37=0, ir_in=3 -> take_no_action=4'b1000; take_action stays 0.
- Overrun: while busy, pulse udr with a new word -> jdo unchanged, overrun=1, ir_out=2'b11. Next capture has sr[33]=1. uir -> overrun=0.
- Priority and invalid channel: cdr and sdr in the same cycle with shift_en -> capture only, no shift. With NUM_CH=3, ir_in=3 and udr -> jdo updated, no strobe, busy=0.

Source files
------------

// File: rtl/dbg_slave_pkg.sv
// Shared definitions for the debug-slave command controller: FSM state
// encoding and the bit positions of status fields in the capture word and
// in the IR status return.
package dbg_slave_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PEND  = 2'd2
    } state_e;

    // ir_out status bits
    localparam int IR_BUSY_BIT = 0;
    localparam int IR_OVR_BIT  = 1;

    // Capture-word status bits sit directly above the readback data word.
    function automatic int cap_busy_bit(input int data_w);
        return data_w;
    endfunction

    function automatic int cap_ovr_bit(input int data_w);
        return data_w + 1;
    endfunction

    // The top bit of the update word selects action versus no-action.
    function automatic int act_bit(input int dr_w);
        return dr_w - 1;
    endfunction

endpackage

// File: rtl/dbg_slave_shift_reg.sv
// DR shift register: parallel capture, LSB-first serial out, MSB-first
// serial in. Capture takes priority over shift.
module dbg_slave_shift_reg #(
    parameter int DR_W = 38
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            capture_i,
    input  logic [DR_W-1:0] cap_word_i,
    input  logic            shift_i,
    input  logic            tdi_i,
    output logic [DR_W-1:0] sr_o,
    output logic            tdo_o
);

    logic [DR_W-1:0] sr_q;

    // Load the capture word, or move one bit towards tdo per shift request.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of block order.
        if (reset) begin
            sr_q <= '0;
        end else if (capture_i) begin
            sr_q <= cap_word_i;
        end else if (shift_i) begin
            sr_q <= {tdi_i, sr_q[DR_W-1:1]};
        end
    end

    assign sr_o  = sr_q;
    assign tdo_o = sr_q[0];

endmodule

// File: rtl/dbg_slave_chan_ctrl.sv
// Debug-slave command controller: per-channel capture mux, update latch
// (jdo), one-hot action strobes with a valid/ready handshake towards the
// CPU side, and sticky overrun reporting for updates dropped while busy.
module dbg_slave_chan_ctrl
    import dbg_slave_pkg::*;
#(
    parameter int IR_W   = 2,
    parameter int NUM_CH = 4,
    parameter int DATA_W = 32,
    parameter int DR_W   = 38
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     shift_en,
    input  logic                     cdr,
    input  logic                     sdr,
    input  logic                     udr,
    input  logic                     uir,
    input  logic [IR_W-1:0]          ir_in,
    input  logic                     tdi,
    output logic                     tdo,
    output logic [IR_W-1:0]          ir_out,
    input  logic [NUM_CH*DATA_W-1:0] ch_rdata,
    output logic [DR_W-1:0]          jdo,
    output logic [NUM_CH-1:0]        take_action,
    output logic [NUM_CH-1:0]        take_no_action,
    input  logic                     act_ready,
    output logic                     busy,
    output logic                     overrun
);

    localparam int CAP_BUSY_BIT = cap_busy_bit(DATA_W);
    localparam int CAP_OVR_BIT  = cap_ovr_bit(DATA_W);
    localparam int ACT_BIT      = act_bit(DR_W);

    state_e              state_q;
    logic [DR_W-1:0]     jdo_q;
    logic [NUM_CH-1:0]   act_q;
    logic [NUM_CH-1:0]   no_act_q;
    logic                overrun_q;

    logic [DR_W-1:0]     sr;
    logic [DR_W-1:0]     cap_word_d;
    logic [DATA_W-1:0]   cap_data;
    logic [NUM_CH-1:0]   ch_sel;
    logic                ch_valid;
    logic                shift_fire;
    logic                upd_fire;

    assign busy = (state_q == ST_PEND);

    // Capture beats shift, and both beat update, within a single cycle.
    assign shift_fire = sdr & shift_en & ~cdr;
    assign upd_fire   = udr & ~cdr & ~(sdr & shift_en);

    // Channel demux: select the readback word and one-hot strobe position;
    // an instruction beyond the last channel selects nothing.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        cap_data = '0;
        ch_sel   = '0;
        ch_valid = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ir_in == IR_W'(k)) begin
                cap_data  = ch_rdata[k*DATA_W +: DATA_W];
                ch_sel[k] = 1'b1;
                ch_valid  = 1'b1;
            end
        end
    end

    // Capture word: readback data with busy/overrun status above it.
    always_comb begin
        cap_word_d               = '0;
        cap_word_d[DATA_W-1:0]   = cap_data;
        cap_word_d[CAP_BUSY_BIT] = busy;
        cap_word_d[CAP_OVR_BIT]  = overrun_q;
    end

    dbg_slave_shift_reg #(
        .DR_W (DR_W)
    ) u_shift_reg (
        .clk        (clk),
        .reset      (reset),
        .capture_i  (cdr),
        .cap_word_i (cap_word_d),
        .shift_i    (shift_fire),
        .tdi_i      (tdi),
        .sr_o       (sr),
        .tdo_o      (tdo)
    );

    // Command FSM: latch accepted updates, raise and hold the strobe until
    // act_ready, and flag updates that arrive while a request is pending.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            jdo_q     <= '0;
            act_q     <= '0;
            no_act_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            // A same-cycle overrun below overrides this clear.
            if (uir) begin
                overrun_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE, ST_SHIFT: begin
                    if (upd_fire) begin
                        jdo_q <= sr;
                        if (ch_valid) begin
                            if (sr[ACT_BIT]) begin
                                act_q <= ch_sel;
                            end else begin
                                no_act_q <= ch_sel;
                            end
                            state_q <= ST_PEND;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else if (cdr) begin
                        state_q <= ST_SHIFT;
                    end else if (uir) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_PEND: begin
                    // The accept is honoured even when an update is dropped
                    // in the same cycle.
                    if (act_ready) begin
                        act_q    <= '0;
                        no_act_q <= '0;
                        state_q  <= ST_IDLE;
                    end
                    if (upd_fire) begin
                        overrun_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // IR status return: busy and overrun in the low bits, zeros above.
    always_comb begin
        ir_out = '0;
        for (int b = 0; b < IR_W; b++) begin
            if (b == IR_BUSY_BIT) begin
                ir_out[b] = busy;
            end else if (b == IR_OVR_BIT) begin
                ir_out[b] = overrun_q;
            end
        end
    end

    assign jdo            = jdo_q;
    assign take_action    = act_q;
    assign take_no_action = no_act_q;
    assign overrun        = overrun_q;

endmodule

// File: tb/tb_dbg_slave_chan_ctrl.sv
// Self-checking bench for dbg_slave_chan_ctrl. A four-channel instance is
// the main target; a three-channel instance on the same inputs covers the
// out-of-range channel case.
module tb_dbg_slave_chan_ctrl;

    localparam int IR_W   = 2;
    localparam int DATA_W = 32;
    localparam int DR_W   = 38;

    typedef struct {
        logic [DR_W-1:0] jdo;
        logic [3:0]      act;
        logic [3:0]      no_act;
    } upd_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              shift_en, cdr, sdr, udr, uir, tdi, act_ready;
    logic [IR_W-1:0]   ir_in;
    logic [4*DATA_W-1:0] ch_rdata;

    logic              tdo, busy, overrun;
    logic [IR_W-1:0]   ir_out;
    logic [DR_W-1:0]   jdo;
    logic [3:0]        take_action, take_no_action;

    logic              tdo3, busy3, overrun3;
    logic [IR_W-1:0]   ir_out3;
    logic [DR_W-1:0]   jdo3;
    logic [2:0]        take_action3, take_no_action3;

    int   checks = 0;
    int   errors = 0;
    logic tdo_q[$];
    upd_t upd_q[$];

    localparam logic [DR_W-1:0] W1 = 38'h20_0000_1234;
    localparam logic [DR_W-1:0] W2 = 38'h0F_1234_5678;
    localparam logic [DR_W-1:0] W3 = 38'h3F_FFFF_FFFF;

    always #5 clk = ~clk;

    dbg_slave_chan_ctrl #(
        .IR_W(IR_W), .NUM_CH(4), .DATA_W(DATA_W), .DR_W(DR_W)
    ) dut (
        .clk(clk), .reset(reset), .shift_en(shift_en), .cdr(cdr), .sdr(sdr),
        .udr(udr), .uir(uir), .ir_in(ir_in), .tdi(tdi), .tdo(tdo),
        .ir_out(ir_out), .ch_rdata(ch_rdata), .jdo(jdo),
        .take_action(take_action), .take_no_action(take_no_action),
        .act_ready(act_ready), .busy(busy), .overrun(overrun)
    );

    dbg_slave_chan_ctrl #(
        .IR_W(IR_W), .NUM_CH(3), .DATA_W(DATA_W), .DR_W(DR_W)
    ) dut3 (
        .clk(clk), .reset(reset), .shift_en(shift_en), .cdr(cdr), .sdr(sdr),
        .udr(udr), .uir(uir), .ir_in(ir_in), .tdi(tdi), .tdo(tdo3),
        .ir_out(ir_out3), .ch_rdata(ch_rdata[3*DATA_W-1:0]), .jdo(jdo3),
        .take_action(take_action3), .take_no_action(take_no_action3),
        .act_ready(act_ready), .busy(busy3), .overrun(overrun3)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One shift_en pulse followed by a cycle with sdr high but no shift_en.
    task automatic shift_bit(input logic b);
        if (tdo_q.size() > 0) check("tdo_bit", tdo, tdo_q.pop_front());
        sdr = 1'b1; shift_en = 1'b1; tdi = b;
        cyc();
        shift_en = 1'b0; tdi = 1'b0;
        cyc();
    endtask

    task automatic shift_word(input logic [DR_W-1:0] w);
        for (int i = 0; i < DR_W; i++) shift_bit(w[i]);
        sdr = 1'b0;
    endtask

    task automatic capture(input logic [IR_W-1:0] ch);
        ir_in = ch; cdr = 1'b1;
        cyc();
        cdr = 1'b0;
    endtask

    task automatic push_capture(input logic [DATA_W-1:0] d, input logic b, input logic o);
        logic [DR_W-1:0] w;
        w = {4'b0000, o, b, d};
        for (int i = 0; i < DR_W; i++) tdo_q.push_back(w[i]);
    endtask

    // Drive one udr pulse; when a strobe is expected, queue its model result.
    task automatic update(input logic [IR_W-1:0] ch, input logic [DR_W-1:0] w, input bit expect_req);
        upd_t e;
        if (expect_req) begin
            e.jdo    = w;
            e.act    = w[DR_W-1] ? (4'b0001 << ch) : 4'b0000;
            e.no_act = w[DR_W-1] ? 4'b0000 : (4'b0001 << ch);
            upd_q.push_back(e);
        end
        ir_in = ch; udr = 1'b1;
        cyc();
        udr = 1'b0;
    endtask

    // Wait (bounded) for the request to appear and compare against the queue.
    task automatic expect_update();
        int   n;
        upd_t e;
        n = 0;
        while (!busy && n < 4) begin
            cyc();
            n++;
        end
        check("upd_busy", busy, 1'b1);
        check("upd_latency", n, 0);
        if (upd_q.size() == 0) begin
            check("upd_queue_empty", 1'b1, 1'b0);
        end else begin
            e = upd_q.pop_front();
            check("upd_jdo", jdo, e.jdo);
            check("upd_act", take_action, e.act);
            check("upd_no_act", take_no_action, e.no_act);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; shift_en = 1'b0; cdr = 1'b0; sdr = 1'b0; udr = 1'b0;
        uir = 1'b0; tdi = 1'b0; act_ready = 1'b0; ir_in = '0;
        ch_rdata = {32'hCAFE_F00D, 32'hDEAD_BEEF, 32'h0000_0001, 32'h0123_4567};
        cyc(); cyc();
        check("rst_tdo", tdo, 1'b0);
        check("rst_jdo", jdo, '0);
        check("rst_act", take_action, 4'b0000);
        check("rst_no_act", take_no_action, 4'b0000);
        check("rst_busy", busy, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_ir_out", ir_out, 2'b00);
        @(negedge clk); reset = 1'b0;
        cyc();

        // Capture channel 2 and shift the whole word out with tdi=0.
        push_capture(32'hDEAD_BEEF, 1'b0, 1'b0);
        capture(2'd2);
        shift_word('0);
        check("wrap_tdo", tdo, 1'b0);

        // Action request on channel 1, held until act_ready.
        capture(2'd1);
        shift_word(W1);
        update(2'd1, W1, 1'b1);
        expect_update();
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("hold_act", take_action, 4'b0010);
            check("hold_busy", busy, 1'b1);
        end
        act_ready = 1'b1;
        cyc();
        act_ready = 1'b0;
        check("accept_act", take_action, 4'b0000);
        check("accept_busy", busy, 1'b0);
        check("accept_jdo", jdo, W1);
        act_ready = 1'b1;
        cyc();
        act_ready = 1'b0;
        check("idle_ready_busy", busy, 1'b0);
        check("idle_ready_act", take_action, 4'b0000);

        // No-action request on channel 3, then an overrun while pending.
        capture(2'd3);
        shift_word(W2);
        update(2'd3, W2, 1'b1);
        expect_update();
        check("pend_ir_out", ir_out, 2'b01);
        capture(2'd0);
        shift_word(W3);
        update(2'd0, W3, 1'b0);
        check("ovr_jdo", jdo, W2);
        check("ovr_no_act", take_no_action, 4'b1000);
        check("ovr_act", take_action, 4'b0000);
        check("ovr_flag", overrun, 1'b1);
        check("ovr_ir_out", ir_out, 2'b11);
        push_capture(32'hDEAD_BEEF, 1'b1, 1'b1);
        capture(2'd2);
        shift_word('0);
        uir = 1'b1;
        cyc();
        uir = 1'b0;
        check("uir_clr_ovr", overrun, 1'b0);
        check("uir_keep_busy", busy, 1'b1);
        // Accept and a dropped update in the same cycle.
        act_ready = 1'b1; udr = 1'b1;
        cyc();
        act_ready = 1'b0; udr = 1'b0;
        check("acc_ovr_busy", busy, 1'b0);
        check("acc_ovr_no_act", take_no_action, 4'b0000);
        check("acc_ovr_flag", overrun, 1'b1);
        check("acc_ovr_jdo", jdo, W2);
        uir = 1'b1;
        cyc();
        uir = 1'b0;
        check("uir_ir_out", ir_out, 2'b00);

        // Capture and shift in the same cycle: capture only.
        ir_in = 2'd1; cdr = 1'b1; sdr = 1'b1; shift_en = 1'b1; tdi = 1'b0;
        cyc();
        cdr = 1'b0; shift_en = 1'b0;
        check("prio_tdo", tdo, 1'b1);
        cyc(); cyc(); cyc();
        check("sdr_no_en_tdo", tdo, 1'b1);
        sdr = 1'b0;

        // Reset in the middle of a shift with a request pending and overrun set.
        capture(2'd2);
        shift_word(W1);
        update(2'd1, W1, 1'b1);
        expect_update();
        update(2'd2, W1, 1'b0);
        check("pre_rst_ovr", overrun, 1'b1);
        capture(2'd2);
        for (int i = 0; i < 10; i++) shift_bit(1'b1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_tdo", tdo, 1'b0);
        check("mid_rst_jdo", jdo, '0);
        check("mid_rst_act", take_action, 4'b0000);
        check("mid_rst_no_act", take_no_action, 4'b0000);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_ovr", overrun, 1'b0);
        check("mid_rst_ir_out", ir_out, 2'b00);
        sdr = 1'b0;
        @(negedge clk); reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("post_rst_act", take_action, 4'b0000);
            check("post_rst_busy", busy, 1'b0);
            check("post_rst_tdo", tdo, 1'b0);
        end

        // Out-of-range channel on the three-channel instance.
        capture(2'd3);
        shift_word(W1);
        update(2'd3, W1, 1'b1);
        check("inv_jdo", jdo3, W1);
        check("inv_act", take_action3, 3'b000);
        check("inv_no_act", take_no_action3, 3'b000);
        check("inv_busy", busy3, 1'b0);
        expect_update();
        act_ready = 1'b1;
        cyc();
        act_ready = 1'b0;
        check("final_busy", busy, 1'b0);

        check("sb_drained", tdo_q.size() + upd_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
